n_bit_iter_shifter: RTL and testbench

N_BIT_ITER_SHIFTER -- requirements
Module: n_bit_iter_shifter

---
 rtl/n_bit_iter_shifter.sv | 106 ++++++++++
 tb/tb_n_bit_iter_shifter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/n_bit_iter_shifter.sv
// Iterative shifter: SLL/SRL/SRA/ROL, moving up to STEP bit positions per cycle.
// A request is accepted in IDLE or DONE; done pulses for one cycle with the result.
module n_bit_iter_shifter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [1:0]                 op,
    input  logic [WIDTH-1:0]           operand,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    input  logic                       kill,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH-1:0]           result
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W+1)'(STEP);
    localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W+1)'(WIDTH);

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_ROL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t               state, nstate;
    logic [WIDTH-1:0]     work;
    logic [1:0]           op_q;
    logic [SHAMT_W-1:0]   remaining;

    logic                 accept;
    logic [SHAMT_W:0]     k_ext;
    logic [SHAMT_W-1:0]   k;
    logic [SHAMT_W:0]     rol_back;
    logic [WIDTH-1:0]     shifted;
    logic                 last_step;

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == SHIFT);
    assign done  = (state == DONE);

    always_comb begin
        accept    = start & ready & ~kill;
        // k never exceeds remaining, so it always fits in SHAMT_W bits even when STEP == WIDTH
        k_ext     = ({1'b0, remaining} < STEP_C) ? {1'b0, remaining} : STEP_C;
        k         = k_ext[SHAMT_W-1:0];
        rol_back  = WIDTH_C - {1'b0, k};
        last_step = (remaining == k);
        shifted   = work;
        case (op_q)
            OP_SLL:  shifted = work << k;
            OP_SRL:  shifted = work >> k;
            OP_SRA:  shifted = $signed(work) >>> k;
            OP_ROL:  shifted = (work << k) | (work >> rol_back);
            default: shifted = work;
        endcase

        nstate = state;
        case (state)
            IDLE: begin
                if (accept) nstate = (shamt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (kill)           nstate = IDLE;
                else if (last_step) nstate = DONE;
            end
            DONE: begin
                if (accept) nstate = (shamt == '0) ? DONE : SHIFT;
                else        nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            op_q      <= '0;
            remaining <= '0;
            result    <= '0;
        end else begin
            state <= nstate;
            if (accept) begin
                work      <= operand;
                op_q      <= op;
                remaining <= shamt;
                if (shamt == '0) result <= operand;
            end else if (state == SHIFT) begin
                if (kill) begin
                    remaining <= '0;
                end else begin
                    work      <= shifted;
                    remaining <= remaining - k;
                    if (last_step) result <= shifted;
                end
            end
        end
    end

endmodule

// File: tb/tb_n_bit_iter_shifter.sv
// Scoreboard bench for n_bit_iter_shifter (WIDTH=32, STEP=4): stimulus queues
// expected result and done cycle, a negedge monitor pops on every done pulse.
module tb_n_bit_iter_shifter;

    localparam logic [1:0] SLL = 2'b00, SRL = 2'b01, ROL = 2'b10, SRA = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        kill;
    logic        ready, busy, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       nm;
    } exp_t;

    exp_t        sbq[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_res;

    n_bit_iter_shifter #(.WIDTH(32), .STEP(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .operand(operand),
        .shamt(shamt), .kill(kill), .ready(ready), .busy(busy), .done(done),
        .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: cycle=%0d result=%h, expected no done", cyc, result);
            end else begin
                e = sbq.pop_front();
                if (result !== e.res || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL %s: result=%h cycle=%0d, expected result=%h cycle=%0d",
                             e.nm, result, cyc, e.res, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s,
                         input logic [31:0] exp, input int lat, input bit push, input string nm);
        int n = 0;
        while (!ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL %s_ready_timeout: ready=%b, expected 1", nm, ready);
        end
        start = 1'b1; op = o; operand = v; shamt = s;
        if (push) begin
            sbq.push_back('{exp, cyc + lat, nm});
            last_res = exp;
        end
        @(posedge clk); #1;
        start = 1'b0; operand = ~v; shamt = s ^ 5'd7; op = ~o;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((sbq.size() != 0 || done || busy) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0 || done || busy) begin
            checks++;
            errors++;
            $display("FAIL %s_idle_timeout: pending=%0d busy=%b, expected 0 pending and idle",
                     nm, sbq.size(), busy);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; kill = 1'b0; op = SLL; operand = '0; shamt = '0;
        #1;
        chk("reset_ready",  {31'd0, ready}, 32'd1);
        chk("reset_busy",   {31'd0, busy},  32'd0);
        chk("reset_done",   {31'd0, done},  32'd0);
        chk("reset_result", result,         32'd0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // SLL with busy tracking and a start ignored while busy
        issue(SLL, 32'h0000_0001, 5'd5, 32'h0000_0020, 3, 1'b1, "sll_1_5");
        chk("sll_busy_c1", {31'd0, busy}, 32'd1);
        start = 1'b1; op = SRL; operand = 32'hFFFF_0000; shamt = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        chk("sll_busy_c2", {31'd0, busy}, 32'd1);
        wait_idle("sll");

        // back-to-back chain: each issue lands in the previous DONE cycle
        issue(SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9, 1'b1, "sra_msb_31");
        issue(SRL, 32'h8000_0000, 5'd31, 32'h0000_0001, 9, 1'b1, "srl_msb_31");
        issue(ROL, 32'h8000_0001, 5'd1,  32'h0000_0003, 2, 1'b1, "rol_1");
        issue(ROL, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, 1, 1'b1, "rol_0");
        issue(SLL, 32'h0000_0001, 5'd8,  32'h0000_0100, 3, 1'b1, "b2b_sll_8");
        issue(SLL, 32'h1234_5678, 5'd0,  32'h1234_5678, 1, 1'b1, "sll_0");
        issue(SRA, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1, 1'b1, "sra_0");
        issue(SRA, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 2, 1'b1, "sra_pos_4");
        issue(SRA, 32'hF000_0000, 5'd6,  32'hFFC0_0000, 3, 1'b1, "sra_neg_6");
        issue(ROL, 32'h1234_5678, 5'd8,  32'h3456_7812, 3, 1'b1, "rol_8");
        issue(ROL, 32'h8000_0000, 5'd31, 32'h4000_0000, 9, 1'b1, "rol_31");
        issue(SLL, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 9, 1'b1, "sll_31");
        issue(SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 2, 1'b1, "srl_4");
        wait_idle("chain");

        // kill one cycle after accept
        issue(SRL, 32'hFFFF_FFFF, 5'd16, 32'h0, 0, 1'b0, "kill_srl");
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_ready",  {31'd0, ready}, 32'd1);
        chk("kill_busy",   {31'd0, busy},  32'd0);
        chk("kill_done",   {31'd0, done},  32'd0);
        chk("kill_result", result,         last_res);
        repeat (8) @(posedge clk);
        #1;

        // start and kill together: no accept
        start = 1'b1; kill = 1'b1; op = SLL; operand = 32'h3; shamt = 5'd4;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        chk("startkill_busy",   {31'd0, busy}, 32'd0);
        chk("startkill_done",   {31'd0, done}, 32'd0);
        chk("startkill_result", result,        last_res);
        repeat (4) @(posedge clk);
        #1;

        // asynchronous reset between edges in the middle of a shift
        issue(SLL, 32'h0000_0001, 5'd20, 32'h0, 0, 1'b0, "rst_sll");
        @(posedge clk); #1;
        chk("midshift_busy", {31'd0, busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_ready",  {31'd0, ready}, 32'd1);
        chk("async_rst_busy",   {31'd0, busy},  32'd0);
        chk("async_rst_done",   {31'd0, done},  32'd0);
        chk("async_rst_result", result,         32'd0);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        issue(SLL, 32'h0000_0001, 5'd5, 32'h0000_0020, 3, 1'b1, "post_rst_sll");
        wait_idle("post_rst");

        // first accept right after reset release
        #3 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        issue(ROL, 32'h8000_0001, 5'd1, 32'h0000_0003, 2, 1'b1, "first_edge_rol");
        wait_idle("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
